// File: rtl/perm_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perm_arb : two-requester round-robin scheduler for one Keccak perm core  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module perm_arb #(
  parameter int DW      = 200,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_req0,
  input  logic          i_req1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  input  logic          i_pushin0,
  input  logic          i_pushin1,
  input  logic [2:0]    i_dix0,
  input  logic [2:0]    i_dix1,
  input  logic [DW-1:0] i_din0,
  input  logic [DW-1:0] i_din1,
  output logic          o_p_pushin,
  output logic [2:0]    o_p_dix,
  output logic [DW-1:0] o_p_din,
  input  logic          i_p_pushout,
  input  logic [2:0]    i_p_doutix,
  input  logic [DW-1:0] i_p_dout,
  output logic          o_pushout0,
  output logic          o_pushout1,
  output logic [2:0]    o_doutix,
  output logic [DW-1:0] o_dout,
  output logic          o_busy,
  output logic          o_err
);

  localparam int              c_TW   = $clog2(TIMEOUT) + 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_rr, w_rr_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [1:0]      r_gnt, w_gnt_nxt;
  logic [2:0]      r_exp, w_exp_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic            w_fwd, w_route;

  logic            w_own_pin, w_oth_pin;
  logic [2:0]      w_own_dix;
  logic [DW-1:0]   w_own_din;

  logic            r_p_pushin;
  logic [2:0]      r_p_dix;
  logic [DW-1:0]   r_p_din;
  logic            r_pushout0, r_pushout1;
  logic [2:0]      r_doutix;
  logic [DW-1:0]   r_dout;

  assign w_own_pin = r_owner ? i_pushin1 : i_pushin0;
  assign w_oth_pin = r_owner ? i_pushin0 : i_pushin1;
  assign w_own_dix = r_owner ? i_dix1    : i_dix0;
  assign w_own_din = r_owner ? i_din1    : i_din0;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_gnt_nxt   = r_gnt;
    w_exp_nxt   = r_exp;
    w_timer_nxt = r_timer;
    w_fwd       = 1'b0;
    w_route     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pushin0 || i_pushin1 || i_p_pushout) w_err_nxt = 1'b1;
        if (i_req0 || i_req1) begin
          w_owner_nxt = (i_req0 && i_req1) ? r_rr : i_req1;
          w_gnt_nxt   = ((i_req0 && i_req1) ? r_rr : i_req1) ? 2'b10 : 2'b01;
          w_exp_nxt   = 3'd0;
          w_done_nxt  = 1'b0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_oth_pin || i_p_pushout) w_err_nxt = 1'b1;
        if (w_own_pin) begin
          if (w_own_dix == r_exp) begin
            w_fwd     = 1'b1;
            w_exp_nxt = r_exp + 3'd1;
            if (r_exp == 3'd7) begin
              w_timer_nxt = '0;
              w_state_nxt = S_WAIT;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (i_pushin0 || i_pushin1) w_err_nxt = 1'b1;
        if (i_p_pushout) begin
          w_route     = 1'b1;
          w_done_nxt  = (i_p_doutix == 3'd7);
          w_state_nxt = S_DRAIN;
        end else if (r_timer == c_TMAX) begin
          w_err_nxt   = 1'b1;
          w_gnt_nxt   = 2'b00;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + c_TW'(1);
        end
      end
      S_DRAIN: begin
        if (i_pushin0 || i_pushin1) w_err_nxt = 1'b1;
        // Grant is held one extra cycle so it covers the last routed slice.
        if (r_done) begin
          if (i_p_pushout) w_err_nxt = 1'b1;
          w_gnt_nxt   = 2'b00;
          w_rr_nxt    = ~r_owner;
          w_done_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (i_p_pushout) begin
          w_route    = 1'b1;
          w_done_nxt = (i_p_doutix == 3'd7);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_gnt   <= 2'b00;
      r_exp   <= 3'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_gnt   <= w_gnt_nxt;
      r_exp   <= w_exp_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p_pushin <= 1'b0;
      r_p_dix    <= 3'd0;
      r_p_din    <= '0;
      r_pushout0 <= 1'b0;
      r_pushout1 <= 1'b0;
      r_doutix   <= 3'd0;
      r_dout     <= '0;
    end else begin
      r_p_pushin <= w_fwd;
      r_pushout0 <= w_route & ~r_owner;
      r_pushout1 <= w_route & r_owner;
      if (w_fwd) begin
        r_p_dix <= w_own_dix;
        r_p_din <= w_own_din;
      end
      if (w_route) begin
        r_doutix <= i_p_doutix;
        r_dout   <= i_p_dout;
      end
    end
  end

  assign o_gnt0     = r_gnt[0];
  assign o_gnt1     = r_gnt[1];
  assign o_p_pushin = r_p_pushin;
  assign o_p_dix    = r_p_dix;
  assign o_p_din    = r_p_din;
  assign o_pushout0 = r_pushout0;
  assign o_pushout1 = r_pushout1;
  assign o_doutix   = r_doutix;
  assign o_dout     = r_dout;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_perm_arb.sv
`default_nettype none
// tb_perm_arb : directed scoreboard bench for perm_arb (forwarded slices and routed results).
module tb_perm_arb;
  localparam int DW      = 200;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, gnt0, gnt1;
  logic          pushin0, pushin1;
  logic [2:0]    dix0, dix1;
  logic [DW-1:0] din0, din1;
  logic          p_pushin;
  logic [2:0]    p_dix;
  logic [DW-1:0] p_din;
  logic          p_pushout;
  logic [2:0]    p_doutix;
  logic [DW-1:0] p_dout;
  logic          pushout0, pushout1;
  logic [2:0]    doutix;
  logic [DW-1:0] dout;
  logic          busy, err;

  perm_arb #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0(req0), .i_req1(req1), .o_gnt0(gnt0), .o_gnt1(gnt1),
    .i_pushin0(pushin0), .i_pushin1(pushin1),
    .i_dix0(dix0), .i_dix1(dix1), .i_din0(din0), .i_din1(din1),
    .o_p_pushin(p_pushin), .o_p_dix(p_dix), .o_p_din(p_din),
    .i_p_pushout(p_pushout), .i_p_doutix(p_doutix), .i_p_dout(p_dout),
    .o_pushout0(pushout0), .o_pushout1(pushout1),
    .o_doutix(doutix), .o_dout(dout),
    .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] ix; logic [DW-1:0] d; } fwd_t;
  typedef struct packed { logic own; logic [2:0] ix; logic [DW-1:0] d; } res_t;

  fwd_t q_fwd[$];
  res_t q_res[$];
  fwd_t fe;
  res_t re;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (p_pushin) begin
      checks++;
      assert (q_fwd.size() != 0) else begin
        errors++; $error("FAIL fwd_extra obs dix=%0d exp no forward", p_dix);
      end
      if (q_fwd.size() != 0) begin
        fe = q_fwd.pop_front();
        checks++;
        assert ({p_dix, p_din} === {fe.ix, fe.d}) else begin
          errors++; $error("FAIL fwd_slice obs=%0d/%0h exp=%0d/%0h", p_dix, p_din, fe.ix, fe.d);
        end
      end
    end
    if (pushout0 || pushout1) begin
      checks++;
      assert (!(pushout0 && pushout1)) else begin
        errors++; $error("FAIL res_both obs=11 exp one-hot");
      end
      checks++;
      assert (q_res.size() != 0) else begin
        errors++; $error("FAIL res_extra obs ix=%0d exp no result", doutix);
      end
      if (q_res.size() != 0) begin
        re = q_res.pop_front();
        checks++;
        assert ({pushout1, doutix, dout} === {re.own, re.ix, re.d}) else begin
          errors++; $error("FAIL res_slice obs=%0d/%0d/%0h exp=%0d/%0d/%0h",
                           pushout1, doutix, dout, re.own, re.ix, re.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic send(input int r, input logic [2:0] ix, input logic [DW-1:0] d, input bit fwd);
    fwd_t f;
    if (r == 0) begin pushin0 = 1'b1; dix0 = ix; din0 = d; end
    else        begin pushin1 = 1'b1; dix1 = ix; din1 = d; end
    if (fwd) begin f.ix = ix; f.d = d; q_fwd.push_back(f); end
    tick();
    pushin0 = 1'b0; pushin1 = 1'b0;
  endtask

  task automatic pout(input logic [2:0] ix, input logic [DW-1:0] d, input logic own);
    res_t e;
    p_pushout = 1'b1; p_doutix = ix; p_dout = d;
    e.own = own; e.ix = ix; e.d = d; q_res.push_back(e);
    tick();
    p_pushout = 1'b0;
  endtask

  task automatic grant(input int r);
    if (r == 0) req0 = 1'b1; else req1 = 1'b1;
    tick();
    chk1("grant_own", (r == 0) ? gnt0 : gnt1, 1'b1);
    chk1("grant_other", (r == 0) ? gnt1 : gnt0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic load_all(input int r);
    for (int i = 0; i < 8; i++) send(r, 3'(i), rnd(), 1'b1);
  endtask

  task automatic drain_all(input int r);
    tick(); tick();
    for (int i = 0; i < 8; i++) pout(3'(i), rnd(), (r != 0));
    chk1("gnt_through_last", (r == 0) ? gnt0 : gnt1, 1'b1);
    tick();
    chk1("gnt_released", (r == 0) ? gnt0 : gnt1, 1'b0);
    chk1("idle_after_drain", busy, 1'b0);
    chk1("fwd_q_empty", q_fwd.size() == 0, 1'b1);
    chk1("res_q_empty", q_res.size() == 0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; pushin0 = 1'b0; pushin1 = 1'b0;
    dix0 = '0; dix1 = '0; din0 = '0; din1 = '0;
    p_pushout = 1'b0; p_doutix = '0; p_dout = '0;
    #1;
    chk1("rst_ctl_zero", |{gnt0, gnt1, p_pushin, pushout0, pushout1, busy, err}, 1'b0);
    chk1("rst_data_zero", |{p_dix, p_din, doutix, dout}, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // single job from requester 0
    do_reset();
    grant(0);
    load_all(0);
    chk1("wait_busy", busy, 1'b1);
    drain_all(0);
    chk1("job0_err", err, 1'b0);

    // simultaneous requests and round-robin rotation
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk1("both_gnt0", gnt0, 1'b1);
    chk1("both_gnt1_low", gnt1, 1'b0);
    req0 = 1'b0;
    load_all(0);
    drain_all(0);
    chk1("gap_gnt1_low", gnt1, 1'b0);
    tick();
    chk1("rr_second_gnt1", gnt1, 1'b1);
    req1 = 1'b0;
    load_all(1);
    drain_all(1);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk1("rr_toggle_gnt0", gnt0, 1'b1);
    chk1("rr_toggle_gnt1", gnt1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    load_all(0);
    drain_all(0);
    chk1("rr_err", err, 1'b0);

    // skipped slice index is dropped and flagged
    do_reset();
    grant(0);
    send(0, 3'd0, rnd(), 1'b1);
    send(0, 3'd1, rnd(), 1'b1);
    send(0, 3'd3, {25{8'hAA}}, 1'b0);
    chk1("skip_err", err, 1'b1);
    chk1("skip_dropped", p_pushin, 1'b0);
    for (int i = 2; i < 8; i++) send(0, 3'(i), rnd(), 1'b1);
    drain_all(0);
    chk1("skip_err_sticky", err, 1'b1);

    // non-owner pushin during load
    do_reset();
    grant(0);
    send(0, 3'd0, rnd(), 1'b1);
    send(0, 3'd1, rnd(), 1'b1);
    pushin1 = 1'b1; dix1 = 3'd2; din1 = rnd();
    send(0, 3'd2, rnd(), 1'b1);
    chk1("nonowner_err", err, 1'b1);
    send(1, 3'd3, rnd(), 1'b0);
    chk1("nonowner_no_fwd", p_pushin, 1'b0);
    for (int i = 3; i < 8; i++) send(0, 3'(i), rnd(), 1'b1);
    drain_all(0);

    // perm never answers: abort after TIMEOUT cycles
    do_reset();
    grant(0);
    load_all(0);
    repeat (TIMEOUT - 1) tick();
    chk1("to_gnt_hold", gnt0, 1'b1);
    chk1("to_busy_hold", busy, 1'b1);
    chk1("to_err_clear", err, 1'b0);
    tick();
    chk1("to_gnt_drop", gnt0, 1'b0);
    chk1("to_busy_drop", busy, 1'b0);
    chk1("to_err_set", err, 1'b1);
    grant(1);
    load_all(1);
    drain_all(1);

    // asynchronous reset in the middle of a drain
    do_reset();
    grant(0);
    load_all(0);
    tick(); tick();
    for (int i = 0; i < 4; i++) pout(3'(i), rnd(), 1'b0);
    #5;
    do_reset();
    grant(1);
    load_all(1);
    drain_all(1);
    chk1("post_reset_err", err, 1'b0);

    chk1("final_fwd_q_empty", q_fwd.size() == 0, 1'b1);
    chk1("final_res_q_empty", q_res.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
